// File: rtl/diag_walker.sv
// diag_walker: enumerates every (x,y) in [0,KMAX]^2 along anti-diagonals
// d = x+y, d = 0..2*KMAX. Mode 0 walks each diagonal with x increasing;
// mode 1 zigzags (x increases on even d, decreases on odd d).
//
// Output handshake: a pair transfers on any rising edge where
// out_valid && out_ready. out_valid stays high for the whole walk, and the
// presented pair (x, y, diag, idx, last) is stable until it transfers.
// abort beats a simultaneous transfer and start, and reset beats everything.
module diag_walker #(
    parameter int W    = 4,
    parameter int KMAX = 2**W - 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           mode,
    input  logic           abort,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [W-1:0]   x,
    output logic [W-1:0]   y,
    output logic [W:0]     diag,
    output logic [2*W-1:0] idx,
    output logic           last,
    output logic           done,
    output logic           busy,
    output logic           fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Coordinate arithmetic runs one bit wider than the coordinates so that
    // diagonal indices up to 2*KMAX (and 2*KMAX+1 as a look-ahead) never wrap.
    localparam logic [W:0]     KM    = KMAX[W:0];
    localparam logic [W:0]     ONE_E = 1;
    localparam logic [2*W-1:0] ONE_I = 1;

    state_t state;
    logic   mode_q;

    // Smallest legal x on diagonal d.
    function automatic logic [W:0] diag_lo(input logic [W:0] d);
        diag_lo = (d > KM) ? (d - KM) : '0;
    endfunction

    // Largest legal x on diagonal d.
    function automatic logic [W:0] diag_hi(input logic [W:0] d);
        diag_hi = (d < KM) ? d : KM;
    endfunction

    logic [W:0] x_e;
    logic [W:0] lo_cur;
    logic [W:0] hi_cur;
    logic [W:0] diag_inc;
    logic       going_up;
    logic       next_up;
    logic       at_end;
    logic [W:0] next_d;
    logic [W:0] next_x_e;
    logic [W:0] next_y_e;
    logic       next_last;
    logic       xfer;

    assign x_e  = {1'b0, x};
    assign xfer = out_valid && out_ready;

    // Successor of the currently presented pair.
    always_comb begin
        lo_cur    = diag_lo(diag);
        hi_cur    = diag_hi(diag);
        diag_inc  = diag + ONE_E;
        going_up  = !mode_q || !diag[0];
        next_up   = !mode_q || !diag_inc[0];
        at_end    = going_up ? (x_e == hi_cur) : (x_e == lo_cur);
        next_d    = diag;
        next_x_e  = x_e;
        if (at_end) begin
            // Leave this diagonal: start the next one at the end its
            // direction begins from.
            next_d   = diag_inc;
            next_x_e = next_up ? diag_lo(diag_inc) : diag_hi(diag_inc);
        end else if (going_up) begin
            next_x_e = x_e + ONE_E;
        end else begin
            next_x_e = x_e - ONE_E;
        end
        next_y_e  = next_d - next_x_e;
        next_last = (next_x_e == KM) && (next_y_e == KM);
    end

    // Control FSM and registered pair outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            last      <= 1'b0;
            x         <= '0;
            y         <= '0;
            diag      <= '0;
            idx       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= RUN;
                        mode_q    <= mode;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        x         <= '0;
                        y         <= '0;
                        diag      <= '0;
                        idx       <= '0;
                        last      <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        last      <= 1'b0;
                        x         <= '0;
                        y         <= '0;
                        diag      <= '0;
                        idx       <= '0;
                    end else if (xfer) begin
                        if (last) begin
                            // Final pair accepted: pulse done and clear down.
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            last      <= 1'b0;
                            x         <= '0;
                            y         <= '0;
                            diag      <= '0;
                            idx       <= '0;
                        end else begin
                            x    <= next_x_e[W-1:0];
                            y    <= next_y_e[W-1:0];
                            diag <= next_d;
                            idx  <= idx + ONE_I;
                            last <= next_last;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: doc/diag_walker.md
DIAG_WALKER -- requirements
Module: diag_walker

Interface
REQ-001 Parameter W, default 4: coordinate width in bits.
REQ-002 Parameter KMAX, default 2**W-1: maximum coordinate value; legal range 1..2**W-1.
REQ-003 clk  input  1  rising-edge clock; reset, synchronous, active-high; clock clk.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 start  input  1  begin a walk; sampled only in IDLE.
REQ-006 mode  input  1  0 = fixed-direction diagonals, 1 = zigzag; sampled with start.
REQ-007 abort  input  1  terminate the walk; return to IDLE without done.
REQ-008 out_ready  input  1  consumer accepts the current pair.
REQ-009 out_valid  output  1  x/y/diag/idx/last hold a valid pair.
REQ-010 x, y  output  W each  current coordinate pair.
REQ-011 diag  output  W+1  current anti-diagonal index d = x+y.
REQ-012 idx  output  2W  0-based ordinal of the current pair in the walk.
REQ-013 last  output  1  current pair is (KMAX,KMAX).
REQ-014 done  output  1  one-cycle pulse after the final pair transfers.
REQ-015 busy  output  1  high in RUN.

Function
REQ-016 The block SHALL have two states, IDLE and RUN.
REQ-017 The walk SHALL enumerate every pair in [0,KMAX]^2 exactly once, (KMAX+1)^2 pairs, diagonal by diagonal for d = 0..2*KMAX.
REQ-018 On diagonal d, x SHALL span max(0,d-KMAX)..min(d,KMAX), with y = d-x.
REQ-019 In mode 0, x SHALL increase along every diagonal.
REQ-020 In mode 1, x SHALL increase on even d and decrease on odd d.
REQ-021 Mode SHALL be latched at start and held for the whole walk.
REQ-022 IDLE with start=1 and abort=0 SHALL enter RUN next cycle with x=0, y=0, diag=0, idx=0, out_valid=1.
REQ-023 A transfer occurs when out_valid && out_ready; each transfer SHALL advance to the next pair on the following cycle, with idx incremented.
REQ-024 While out_valid=1 and out_ready=0, x, y, diag, idx and last SHALL hold stable.
REQ-025 out_valid SHALL stay 1 throughout RUN, with no bubbles between pairs.
REQ-026 The end-of-diagonal test and the next-diagonal start point SHALL use W+1-bit arithmetic, so that KMAX=2**W-1 does not overflow (d reaches 2*KMAX).
REQ-027 The transfer of the last pair SHALL return the block to IDLE, with done=1 for exactly the next cycle and out_valid=0.
REQ-028 start in RUN SHALL be ignored.
REQ-029 abort in RUN SHALL return the block to IDLE next cycle, with no done.
REQ-030 abort SHALL take priority over a simultaneous transfer and over a simultaneous start.
REQ-031 In IDLE, x, y, diag, idx and last SHALL be 0.
REQ-032 start arriving in the done cycle SHALL be accepted (the state is IDLE), so back-to-back walks are possible.

Reset
REQ-033 reset SHALL take priority over all inputs, including mid-walk.
REQ-034 On reset, state = IDLE, latched mode = 0, and out_valid = busy = done = last = 0.
REQ-035 On reset, x = y = diag = idx = 0.

Verification
REQ-036 KMAX=3, mode=0, out_ready=1, pulse start -> out_valid rises next cycle; pair order (0,0)(0,1)(1,0)(0,2)(1,1)(2,0)(0,3)(1,2)(2,1)(3,0)(1,3)(2,2)(3,1)(2,3)(3,2)(3,3); last only on (3,3) with idx=15; done pulses the cycle after; busy falls.
REQ-037 KMAX=3, mode=1 -> order (0,0)(1,0)(0,1)(0,2)(1,1)(2,0)(3,0)(2,1)(1,2)(0,3)(1,3)(2,2)(3,1)(3,2)(2,3)(3,3); diag at (3,0) = 3.
REQ-038 W=4, KMAX=15 default, out_ready=1 -> 256 transfers, final pair (15,15), diag=30, idx=255; no pair repeated or skipped.
REQ-039 KMAX=3, out_ready toggled pseudo-randomly, with start asserted mid-walk -> outputs held while stalled; same sequence as REQ-036; mid-walk start has no effect.
REQ-040 KMAX=3, abort asserted at idx=5 together with out_ready=1 -> IDLE next cycle, no done, outputs 0; a subsequent start restarts at (0,0).
REQ-041 reset asserted at idx=7 -> next cycle all outputs 0, state IDLE; start in the same cycle as reset is ignored.
